// File: rtl/display_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_pkg
// Shared definitions for the multiplexed 7-segment scan controller:
//   - scan_state_e : slot phase (BLANK = anti-ghosting gap, DRIVE = anode on)
//   - SEG_OFF      : all segments dark (segments are active-low)
//   - BCD_W        : width of one digit code
//   - digit_is_zero: a digit is a leading-zero candidate when its code is 0
//                    and its decimal point is not lit
// -----------------------------------------------------------------------------
package display_scan_ctrl_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_DRIVE = 1'b1
    } scan_state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int         BCD_W   = 4;

    function automatic logic digit_is_zero(input logic [BCD_W-1:0] code,
                                           input logic             dp);
        return (code == '0) && !dp;
    endfunction

endpackage

// File: rtl/display_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl_if
// Host-side load bus of the scan controller.
//   load      : one-cycle request to display digits_in/dp_in
//   digits_in : BCD digits, digit i at [4i+3:4i], digit 0 least significant
//   dp_in     : decimal point per digit, active-high
//   blank_lz  : leading-zero blanking enable (level, used live)
//   load_ack  : one-cycle pulse when a pending load becomes the displayed value
// Modports: master = host, slave = controller.
// -----------------------------------------------------------------------------
interface display_scan_ctrl_if
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS = 4
);

    logic                        load;
    logic [BCD_W*NUM_DIGITS-1:0] digits_in;
    logic [NUM_DIGITS-1:0]       dp_in;
    logic                        blank_lz;
    logic                        load_ack;

    modport master (
        output load,
        output digits_in,
        output dp_in,
        output blank_lz,
        input  load_ack
    );

    modport slave (
        input  load,
        input  digits_in,
        input  dp_in,
        input  blank_lz,
        output load_ack
    );

endinterface

// File: rtl/display_scan_ctrl_scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Free-running 0..SCAN_DIV-1 slot counter for the display scan.
//   clk          : rising-edge clock
//   rst_n        : asynchronous active-low reset (counter to 0)
//   slot_start_o : high in the last cycle of a slot, so the next cycle is the
//                  first cycle of a new slot
//   blank_done_o : high in the last anti-ghosting cycle of a slot
// -----------------------------------------------------------------------------
module scan_prescaler #(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_start_o,
    output logic blank_done_o
);

    localparam int               CNT_W      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign slot_start_o = (cnt_q == CNT_LAST);
    assign blank_done_o = (cnt_q == BLANK_LAST);

endmodule

// File: rtl/display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// display_scan_ctrl
// Time-multiplexed scan controller for NUM_DIGITS common-anode 7-segment
// digits sharing one external BCD decoder.
//   clk       : rising-edge clock
//   rst_n     : asynchronous active-low reset
//   bus       : host load bus (load, digits_in, dp_in, blank_lz, load_ack)
//   dec_digit : BCD code presented to the shared decoder
//   dec_dp    : decimal-point request to the decoder, active-high
//   seg_in    : decoder output, active-low, bit 7 = dp
//   seg_out   : seg_in registered, to the segment pins, active-low
//   anode_n   : digit enables, active-low, at most one low
//
// Each slot is SCAN_DIV cycles: BLANK_CYCLES with every anode off (the decoder
// input switches to the new digit at the start of this gap and seg_out settles)
// followed by DRIVE with the slot's anode on. New values are double-buffered:
// a load lands in a pending register and only moves to the displayed shadow
// register at a frame boundary, so a frame is never shown half old/half new.
// load_ack is registered: it is high in the first cycle of the frame that
// shows the transferred value.
// -----------------------------------------------------------------------------
module display_scan_ctrl
    import display_scan_ctrl_pkg::*;
#(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    display_scan_ctrl_if.slave    bus,
    output logic [BCD_W-1:0]      dec_digit,
    output logic                  dec_dp,
    input  logic [7:0]            seg_in,
    output logic [7:0]            seg_out,
    output logic [NUM_DIGITS-1:0] anode_n
);

    localparam int               IDX_W    = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam int               DIG_W    = BCD_W * NUM_DIGITS;

    // ---------------------------------------------------------------- state
    scan_state_e           state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;

    logic [DIG_W-1:0]      pend_dig_q, pend_dig_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d;
    logic                  pend_vld_q, pend_vld_d;

    logic [DIG_W-1:0]      shadow_dig_q, shadow_dig_d;
    logic [NUM_DIGITS-1:0] shadow_dp_q, shadow_dp_d;

    logic                  load_ack_q, load_ack_d;
    logic [NUM_DIGITS-1:0] anode_q, anode_d;
    logic [BCD_W-1:0]      dec_digit_q, dec_digit_d;
    logic                  dec_dp_q, dec_dp_d;
    logic [7:0]            seg_q;

    logic                  slot_start;
    logic                  blank_done;
    logic                  frame_wrap;

    logic [BCD_W-1:0]      shadow_digit_w [NUM_DIGITS];
    logic [NUM_DIGITS-1:1] zero_w;
    logic [NUM_DIGITS-1:0] blank_w;
    logic                  lz_run;

    // ------------------------------------------------------------ prescaler
    scan_prescaler #(
        .SCAN_DIV     (SCAN_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_prescaler (
        .clk          (clk),
        .rst_n        (rst_n),
        .slot_start_o (slot_start),
        .blank_done_o (blank_done)
    );

    // Last cycle of the last digit's slot: the next cycle starts digit 0.
    assign frame_wrap = slot_start && (idx_q == IDX_LAST);

    // ------------------------------------------------------------ scan FSM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        case (state_q)
            ST_BLANK: begin
                if (blank_done) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (slot_start) begin
                    state_d = ST_BLANK;
                    // Explicit wrap keeps non-power-of-2 digit counts in range.
                    idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_BLANK;
            end
        endcase
    end

    // ---------------------------------------------- pending / shadow buffer
    always_comb begin
        pend_dig_d   = pend_dig_q;
        pend_dp_d    = pend_dp_q;
        pend_vld_d   = pend_vld_q;
        shadow_dig_d = shadow_dig_q;
        shadow_dp_d  = shadow_dp_q;
        load_ack_d   = 1'b0;

        // Transfer uses the registered pending contents, so a load in the
        // wrap cycle itself is not part of this transfer.
        if (frame_wrap && pend_vld_q) begin
            shadow_dig_d = pend_dig_q;
            shadow_dp_d  = pend_dp_q;
            pend_vld_d   = 1'b0;
            load_ack_d   = 1'b1;
        end

        // Latest load wins; it re-arms pending even in the wrap cycle.
        if (bus.load) begin
            pend_dig_d = bus.digits_in;
            pend_dp_d  = bus.dp_in;
            pend_vld_d = 1'b1;
        end
    end

    // ------------------------------------------------ leading-zero blanking
    // Evaluated on the next-cycle shadow so anode/decoder registers and the
    // blanking mask always describe the same displayed value.
    genvar gi;
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign shadow_digit_w[gi] = shadow_dig_d[BCD_W*gi +: BCD_W];
    end

    for (gi = 1; gi < NUM_DIGITS; gi++) begin : g_zero
        assign zero_w[gi] = digit_is_zero(shadow_digit_w[gi], shadow_dp_d[gi]);
    end

    // Walk down from the most significant digit; blanking stops at the first
    // non-zero digit (or lit dp). Digit 0 always shows.
    always_comb begin
        lz_run  = bus.blank_lz;
        blank_w = '0;
        for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
            lz_run     = lz_run && zero_w[i];
            blank_w[i] = lz_run;
        end
    end

    // --------------------------------------------------- output next-state
    always_comb begin
        anode_d     = '1;
        dec_digit_d = shadow_digit_w[idx_d];
        dec_dp_d    = shadow_dp_d[idx_d];
        if ((state_d == ST_DRIVE) && !blank_w[idx_d]) begin
            anode_d[idx_d] = 1'b0;
        end
    end

    // ------------------------------------------------------------ registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_BLANK;
            idx_q        <= '0;
            pend_dig_q   <= '0;
            pend_dp_q    <= '0;
            pend_vld_q   <= 1'b0;
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            load_ack_q   <= 1'b0;
            anode_q      <= '1;
            dec_digit_q  <= '0;
            dec_dp_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            pend_dig_q   <= pend_dig_d;
            pend_dp_q    <= pend_dp_d;
            pend_vld_q   <= pend_vld_d;
            shadow_dig_q <= shadow_dig_d;
            shadow_dp_q  <= shadow_dp_d;
            load_ack_q   <= load_ack_d;
            anode_q      <= anode_d;
            dec_digit_q  <= dec_digit_d;
            dec_dp_q     <= dec_dp_d;
        end
    end

    // Decoder output is re-timed every cycle; the BLANK gap hides its
    // one-cycle latency after the decoder input switches digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= SEG_OFF;
        end else begin
            seg_q <= seg_in;
        end
    end

    assign bus.load_ack = load_ack_q;
    assign anode_n      = anode_q;
    assign dec_digit    = dec_digit_q;
    assign dec_dp       = dec_dp_q;
    assign seg_out      = seg_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_display_scan_ctrl
// Directed bench for display_scan_ctrl (NUM_DIGITS=4, SCAN_DIV=8,
// BLANK_CYCLES=2) with a behavioural active-low 7-segment decoder.
// Frame offsets below count negedges from the first cycle of digit 0.
// -----------------------------------------------------------------------------
module tb_display_scan_ctrl;

    localparam int ND = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] dec_digit;
    logic       dec_dp;
    logic [7:0] seg_in;
    logic [7:0] seg_out;
    logic [3:0] anode_n;

    int checks = 0;
    int errors = 0;

    display_scan_ctrl_if #(.NUM_DIGITS(ND)) bus_if ();

    display_scan_ctrl #(
        .NUM_DIGITS   (ND),
        .SCAN_DIV     (8),
        .BLANK_CYCLES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus_if),
        .dec_digit (dec_digit),
        .dec_dp    (dec_dp),
        .seg_in    (seg_in),
        .seg_out   (seg_out),
        .anode_n   (anode_n)
    );

    always #5 clk = ~clk;

    // External decoder: gfedcba active-low, codes > 9 dark.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb seg_in = {~dec_dp, seg7(dec_digit)};

    typedef struct packed {
        logic [15:0] digits;
        logic [3:0]  dp;
        logic        lz;
        int          delay;    // frame offset of the load cycle
        logic [15:0] exp_an;   // DRIVE anode pattern, slot s at [4s+:4]
        logic [31:0] exp_seg;  // seg_out, slot s at [8s+:8]
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_load(input logic [15:0] d, input logic [3:0] dp, input logic lz);
        bus_if.digits_in = d;
        bus_if.dp_in     = dp;
        bus_if.blank_lz  = lz;
        bus_if.load      = 1'b1;
        @(negedge clk);
        bus_if.load      = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (bus_if.load_ack !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout: got no load_ack, expected one within 200 cycles");
        end
    endtask

    // Starts at offset 0 of a frame, ends at offset 0 of the next frame.
    task automatic frame_check(input string tag, input logic [15:0] digits,
                               input logic [15:0] exp_an, input logic [31:0] exp_seg,
                               input logic ack_first);
        for (int s = 0; s < ND; s++) begin
            for (int c = 0; c < 8; c++) begin
                chk($sformatf("%s s%0d c%0d anode", tag, s, c), anode_n,
                    (c < 2) ? 4'hF : exp_an[4*s +: 4]);
                if (c >= 2) begin
                    chk($sformatf("%s s%0d c%0d seg", tag, s, c), seg_out, exp_seg[8*s +: 8]);
                end
                if (c == 2) begin
                    chk($sformatf("%s s%0d dec_digit", tag, s), dec_digit, digits[4*s +: 4]);
                end
                chk($sformatf("%s s%0d c%0d ack", tag, s, c), bus_if.load_ack,
                    (s == 0 && c == 0) ? ack_first : 1'b0);
                @(negedge clk);
            end
        end
    endtask

    int n;

    initial begin
        vecs[0] = '{16'h1234, 4'b0100, 1'b0,  5, 16'h7BDE, 32'hF924B099};
        vecs[1] = '{16'h0050, 4'b0000, 1'b1, 12, 16'hFFDE, 32'hC0C092C0};
        vecs[2] = '{16'h0050, 4'b0100, 1'b1, 20, 16'hFBDE, 32'hC04092C0};
        vecs[3] = '{16'h0000, 4'b0000, 1'b1,  0, 16'hFFFE, 32'hC0C0C0C0};
        vecs[4] = '{16'h0000, 4'b0000, 1'b0, 30, 16'h7BDE, 32'hC0C0C0C0};
        vecs[5] = '{16'h9A0F, 4'b1001, 1'b0,  7, 16'h7BDE, 32'h10FFC07F};
        vecs[6] = '{16'h0007, 4'b0010, 1'b1, 17, 16'hFFDE, 32'hC0C040F8};
        vecs[7] = '{16'h8008, 4'b0000, 1'b1, 25, 16'h7BDE, 32'h80C0C080};

        rst_n            = 1'b0;
        bus_if.load      = 1'b0;
        bus_if.digits_in = '0;
        bus_if.dp_in     = '0;
        bus_if.blank_lz  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset anode", anode_n, 4'hF);
        chk("reset seg", seg_out, 8'hFF);
        chk("reset dec_digit", dec_digit, 4'h0);
        chk("reset dec_dp", dec_dp, 1'b0);
        chk("reset ack", bus_if.load_ack, 1'b0);
        $display("tb: reset state sampled");

        // Scan after release, nothing loaded
        rst_n = 1'b1;
        frame_check("idle", 16'h0000, 16'h7BDE, 32'hC0C0C0C0, 1'b0);
        $display("tb: idle frame after reset");

        // Table of loads at various frame offsets
        for (int v = 0; v < 8; v++) begin
            repeat (vecs[v].delay) @(negedge clk);
            apply_load(vecs[v].digits, vecs[v].dp, vecs[v].lz);
            wait_ack(n);
            chk($sformatf("vec%0d ack_latency", v), n, 31 - vecs[v].delay);
            frame_check($sformatf("vec%0d", v), vecs[v].digits, vecs[v].exp_an,
                        vecs[v].exp_seg, 1'b1);
            $display("tb: vec %0d digits=%h dp=%b lz=%0d ack after %0d cycles",
                     v, vecs[v].digits, vecs[v].dp, vecs[v].lz, n);
        end

        // Two loads in one frame: latest wins, single ack
        repeat (3) @(negedge clk);
        apply_load(16'h1111, 4'b0000, 1'b0);
        repeat (6) @(negedge clk);
        apply_load(16'h9999, 4'b0000, 1'b0);
        wait_ack(n);
        chk("double ack_latency", n, 21);
        frame_check("double", 16'h9999, 16'h7BDE, 32'h90909090, 1'b1);
        frame_check("double2", 16'h9999, 16'h7BDE, 32'h90909090, 1'b0);
        $display("tb: double load 1111/9999 ack after %0d cycles", n);

        // Load in the wrap cycle itself: acked one frame later
        repeat (31) @(negedge clk);
        apply_load(16'h4321, 4'b0000, 1'b0);
        chk("wrap-load no_ack", bus_if.load_ack, 1'b0);
        wait_ack(n);
        chk("wrap-load ack_latency", n, 32);
        frame_check("wrapload", 16'h4321, 16'h7BDE, 32'h99B0A4F9, 1'b1);
        $display("tb: wrap-cycle load 4321 ack after %0d further cycles", n);

        // Reset during digit 2 DRIVE with a load pending
        repeat (2) @(negedge clk);
        apply_load(16'h5678, 4'b0000, 1'b0);
        repeat (17) @(negedge clk);
        chk("pre-reset anode", anode_n, 4'hB);
        #2 rst_n = 1'b0;
        #1;
        chk("async reset anode", anode_n, 4'hF);
        chk("async reset seg", seg_out, 8'hFF);
        chk("async reset ack", bus_if.load_ack, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        frame_check("post-reset", 16'h0000, 16'h7BDE, 32'hC0C0C0C0, 1'b0);
        frame_check("post-reset2", 16'h0000, 16'h7BDE, 32'hC0C0C0C0, 1'b0);
        $display("tb: mid-frame reset, pending 5678 discarded");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scan_ctrl.md
DISPLAY_SCAN_CTRL -- requirements
Module: display_scan_ctrl

Interface
REQ-001 Parameter NUM_DIGITS, 4, number of multiplexed 7-segment digits (2..8).
REQ-002 Parameter SCAN_DIV, 50000, clk cycles per digit slot (>= BLANK_CYCLES+2).
REQ-003 Parameter BLANK_CYCLES, 2, anti-ghosting cycles at the start of each slot with all anodes off (>= 1).
REQ-004 Clock and reset SHALL be: one clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 load  in  1  one-cycle request to display new value.
REQ-008 digits_in  in  4*NUM_DIGITS  BCD digits; digit i = digits_in[4i+3:4i]; digit 0 is least significant.
REQ-009 dp_in  in  NUM_DIGITS  decimal point per digit, active-high.
REQ-010 blank_lz  in  1  leading-zero blanking enable.
REQ-011 dec_digit  out  4  BCD code driven to the shared external decoder.
REQ-012 dec_dp  out  1  decimal-point request to the decoder, active-high.
REQ-013 seg_in  in  8  decoder segment output; active-low; bit 7 = dp.
REQ-014 seg_out  out  8  registered segments to the pins, active-low.
REQ-015 anode_n  out  NUM_DIGITS  digit enables, active-low, at most one low.
REQ-016 load_ack  out  1  one-cycle pulse when a pending load becomes the displayed value.

Function
REQ-017 Capture: load=1 SHALL copy digits_in/dp_in into the pending register and set pending; a later load before transfer overwrites it (latest wins, single ack).
REQ-018 Transfer: at the frame boundary (slot index wraps NUM_DIGITS-1 -> 0), if pending, pending -> shadow, pending cleared, load_ack=1 that cycle; uses pending contents as of the start of the cycle. A load in the boundary cycle stays pending until the next frame.
REQ-019 FSM states: BLANK, DRIVE. BLANK lasts BLANK_CYCLES cycles; DRIVE lasts SCAN_DIV-BLANK_CYCLES cycles; DRIVE end -> BLANK with index+1 (mod NUM_DIGITS).
REQ-020 On entering BLANK, dec_digit/dec_dp SHALL present shadow digit/dp of the new index; all anode_n high throughout BLANK.
REQ-021 seg_out SHALL register seg_in every cycle (1-cycle latency), so it is stable before DRIVE begins.
REQ-022 In DRIVE, anode_n[index]=0 unless the digit is blanked; blanked digits keep all anodes high.
REQ-023 Leading-zero blanking (blank_lz=1): digit i blanked iff it and all higher digits are 0 with dp clear; digit 0 is never blanked.
REQ-024 Digit codes > 9 SHALL pass unchanged to the decoder (decoder blanks them); no error flag.
REQ-025 The prescaler SHALL count 0..SCAN_DIV-1 and wrap; index arithmetic wraps modulo NUM_DIGITS for non-power-of-2 counts.

Reset
REQ-026 rst_n low SHALL asynchronously force: state BLANK, index 0, prescaler 0, anode_n all 1, seg_out 8'hFF, dec_digit 0, dec_dp 0, load_ack 0, pending flag 0, shadow and pending all 0.
REQ-027 Reset mid-frame SHALL discard any pending load without ack; scanning restarts at digit 0 BLANK on the first clk after release.

Structure
REQ-028 A shared package SHALL hold the state enum (BLANK, DRIVE) and the SEG_OFF 8'hFF constant.
REQ-029 One sub-module scan_prescaler (SCAN_DIV counter, slot_start/blank_done strobes); the decoder stays external and shared.

Verification (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2)
REQ-030 Reset release, no load -> anodes cycle 1110,1101,1011,0111, low 6 of every 8 cycles; seg_out=8'hC0 (zero, dp off).
REQ-031 load digits 16'h1234, dp 4'b0100 mid-frame -> load_ack one cycle at next wrap; digit 2 slot shows seg_out=8'h24 (dp lit, bit 7=0).
REQ-032 Two loads (16'h1111 then 16'h9999) in the same frame -> a single load_ack; 16'h9999 displayed, 16'h1111 never.
REQ-033 blank_lz=1, digits 16'h0050 -> digits 3 and 2 keep anode_n high in DRIVE; digits 1 and 0 drive; with dp_in=4'b0100, digit 2 drives.
REQ-034 load asserted exactly in the wrap cycle -> no ack that cycle; ack at the following wrap.
REQ-035 rst_n pulsed low during digit 2 DRIVE with a load pending -> anode_n=4'hF and seg_out=8'hFF immediately; no load_ack; restart at digit 0 showing zeros.
